// File: rtl/buyruk_getir_if.sv
// Decode-side handshake of the fetch unit: head of the fetch FIFO plus the
// decode accept signal.
interface buyruk_getir_if;
    logic        buyruk_gecerli;
    logic [31:0] buyruk;
    logic [31:0] buyruk_pc;
    logic        buyruk_hazir;

    modport master (
        output buyruk_gecerli,
        output buyruk,
        output buyruk_pc,
        input  buyruk_hazir
    );

    modport slave (
        input  buyruk_gecerli,
        input  buyruk,
        input  buyruk_pc,
        output buyruk_hazir
    );
endinterface

// File: rtl/buyruk_getir.sv
// Instruction fetch unit: drives a 1-cycle-latency instruction memory, buffers
// fetched words in a 2-entry FIFO and hands {pc, instruction} to decode.
module buyruk_getir #(
    parameter logic [31:0] BASLANGIC_ADRESI = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    output logic [31:0]   bellek_adres,
    input  logic [31:0]   bellek_veri,
    input  logic          dallan_gecerli,
    input  logic [31:0]   dallan_adres,
    buyruk_getir_if.master cikis,
    output logic          hizasiz_hata
);

    logic [31:0] istek_pc_reg;
    logic [31:0] ucus_pc_reg;
    logic        ucus_reg;
    logic [1:0]  sayac_reg;
    logic        yaz_ptr_reg;
    logic        oku_ptr_reg;
    logic        hata_reg;
    logic [31:0] fifo_pc_reg     [2];
    logic [31:0] fifo_buyruk_reg [2];

    logic        gecerli;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  doluluk;

    assign gecerli = (sayac_reg != 2'd0);
    assign pop     = gecerli & cikis.buyruk_hazir;
    assign push    = ucus_reg & ~dallan_gecerli;

    // Credit check: words already buffered plus the one in flight, minus the one
    // leaving now, must leave room for the word this cycle's read will return.
    assign doluluk = {1'b0, sayac_reg} + {2'b00, ucus_reg} - {2'b00, pop};
    assign issue   = ~dallan_gecerli & (doluluk < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            istek_pc_reg <= BASLANGIC_ADRESI;
            ucus_pc_reg  <= 32'h0;
            ucus_reg     <= 1'b0;
            sayac_reg    <= 2'd0;
            yaz_ptr_reg  <= 1'b0;
            oku_ptr_reg  <= 1'b0;
            hata_reg     <= 1'b0;
        end else if (dallan_gecerli) begin
            // Redirect discards the in-flight read and everything buffered.
            istek_pc_reg <= {dallan_adres[31:2], 2'b00};
            ucus_reg     <= 1'b0;
            sayac_reg    <= 2'd0;
            yaz_ptr_reg  <= 1'b0;
            oku_ptr_reg  <= 1'b0;
            if (dallan_adres[1:0] != 2'b00) begin
                hata_reg <= 1'b1;
            end
        end else begin
            ucus_reg  <= issue;
            sayac_reg <= sayac_reg + {1'b0, push} - {1'b0, pop};
            if (issue) begin
                ucus_pc_reg  <= istek_pc_reg;
                istek_pc_reg <= istek_pc_reg + 32'd4;
            end
            if (push) begin
                yaz_ptr_reg <= ~yaz_ptr_reg;
            end
            if (pop) begin
                oku_ptr_reg <= ~oku_ptr_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    fifo_pc_reg[gi]     <= 32'h0;
                    fifo_buyruk_reg[gi] <= 32'h0;
                end else if (push && (yaz_ptr_reg == 1'(gi))) begin
                    fifo_pc_reg[gi]     <= ucus_pc_reg;
                    fifo_buyruk_reg[gi] <= bellek_veri;
                end
            end
        end
    endgenerate

    assign bellek_adres         = istek_pc_reg;
    assign cikis.buyruk_gecerli = gecerli;
    assign cikis.buyruk         = fifo_buyruk_reg[oku_ptr_reg];
    assign cikis.buyruk_pc      = fifo_pc_reg[oku_ptr_reg];
    assign hizasiz_hata         = hata_reg;

endmodule

// File: tb/tb_buyruk_getir.sv
// Directed bench for buyruk_getir: expected {pc, instruction} pairs go into a
// scoreboard queue, a negedge monitor checks every accepted instruction.
module tb_buyruk_getir;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_veri = 32'h0;
    logic        dallan_gecerli = 1'b0;
    logic [31:0] dallan_adres = 32'h0;
    logic        hizasiz_hata;

    int checks = 0;
    int errors = 0;

    logic [63:0] beklenen_q [$];

    buyruk_getir_if bif ();

    buyruk_getir #(.BASLANGIC_ADRESI(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .bellek_adres   (bellek_adres),
        .bellek_veri    (bellek_veri),
        .dallan_gecerli (dallan_gecerli),
        .dallan_adres   (dallan_adres),
        .cikis          (bif),
        .hizasiz_hata   (hizasiz_hata)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word i holds A000_0000 + i, one-cycle read latency.
    always @(posedge clk) begin
        bellek_veri <= 32'hA000_0000 + (bellek_adres >> 2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bekle(input logic [31:0] pc);
        beklenen_q.push_back({pc, 32'hA000_0000 + (pc >> 2)});
    endtask

    task automatic bekle_dizi(input logic [31:0] ilk, input int adet);
        for (int i = 0; i < adet; i++) begin
            bekle(ilk + 32'(4 * i));
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the next scoreboard entry.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && bif.buyruk_gecerli && bif.buyruk_hazir) begin
            if (beklenen_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %08h instr %08h, expected none at %0t",
                         bif.buyruk_pc, bif.buyruk, $time);
            end else begin
                e = beklenen_q.pop_front();
                chk("deliver_pc", bif.buyruk_pc, e[63:32]);
                chk("deliver_instr", bif.buyruk, e[31:0]);
                $display("accept pc=%08h instr=%08h", bif.buyruk_pc, bif.buyruk);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.buyruk_hazir = 1'b0;
        repeat (3) nxt();

        @(negedge clk);
        chk("reset_valid", 32'(bif.buyruk_gecerli), 32'd0);
        chk("reset_pc", bif.buyruk_pc, 32'h0);
        chk("reset_instr", bif.buyruk, 32'h0);
        chk("reset_hata", 32'(hizasiz_hata), 32'd0);
        chk("reset_adres", bellek_adres, 32'h0);
        nxt();

        // Stream from reset, then redirect to 0x40 while head pc = 0x10.
        rst = 1'b1;
        bif.buyruk_hazir = 1'b1;
        bekle_dizi(32'h0, 5);
        @(negedge clk); chk("c0_valid", 32'(bif.buyruk_gecerli), 32'd0);
        chk("c0_adres", bellek_adres, 32'h0); nxt();
        @(negedge clk); chk("c1_valid", 32'(bif.buyruk_gecerli), 32'd0);
        chk("c1_adres", bellek_adres, 32'h4); nxt();
        @(negedge clk); chk("c2_valid", 32'(bif.buyruk_gecerli), 32'd1); nxt();
        repeat (3) nxt();
        dallan_gecerli = 1'b1;
        dallan_adres   = 32'h40;
        @(negedge clk); chk("redir_head_pc", bif.buyruk_pc, 32'h10); nxt();
        dallan_gecerli = 1'b0;
        chk("q_empty_redir1", 32'(beklenen_q.size()), 32'd0);
        bekle_dizi(32'h40, 9);
        @(negedge clk); chk("redir_n1_valid", 32'(bif.buyruk_gecerli), 32'd0);
        chk("redir_n1_adres", bellek_adres, 32'h40); nxt();
        @(negedge clk); chk("redir_n2_valid", 32'(bif.buyruk_gecerli), 32'd0); nxt();
        @(negedge clk); chk("redir_n3_valid", 32'(bif.buyruk_gecerli), 32'd1);
        chk("redir_n3_pc", bif.buyruk_pc, 32'h40); nxt();
        repeat (3) nxt();

        // Back-pressure for 5 cycles: head held.
        bif.buyruk_hazir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bif.buyruk_gecerli), 32'd1);
            chk("hold_pc", bif.buyruk_pc, 32'h50);
            chk("hold_instr", bif.buyruk, 32'hA000_0014);
            nxt();
        end
        bif.buyruk_hazir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("release_valid", 32'(bif.buyruk_gecerli), 32'd1);
            nxt();
        end

        // Misaligned redirect to 0x102 in the same cycle as a pop of 0x60.
        dallan_gecerli = 1'b1;
        dallan_adres   = 32'h102;
        @(negedge clk); chk("hata_before", 32'(hizasiz_hata), 32'd0);
        chk("redir2_head_pc", bif.buyruk_pc, 32'h60); nxt();
        dallan_gecerli = 1'b0;
        chk("q_empty_redir2", 32'(beklenen_q.size()), 32'd0);
        bekle_dizi(32'h100, 4);
        @(negedge clk); chk("hata_set", 32'(hizasiz_hata), 32'd1);
        chk("redir2_n1_valid", 32'(bif.buyruk_gecerli), 32'd0);
        chk("redir2_n1_adres", bellek_adres, 32'h100); nxt();
        @(negedge clk); chk("redir2_n2_valid", 32'(bif.buyruk_gecerli), 32'd0); nxt();
        @(negedge clk); chk("redir2_n3_pc", bif.buyruk_pc, 32'h100); nxt();
        repeat (2) nxt();

        // Fill the FIFO, then redirect with a pop while full.
        bif.buyruk_hazir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_pc", bif.buyruk_pc, 32'h10C);
            nxt();
        end
        bif.buyruk_hazir = 1'b1;
        dallan_gecerli   = 1'b1;
        dallan_adres     = 32'h200;
        @(negedge clk); chk("redir3_head_pc", bif.buyruk_pc, 32'h10C); nxt();
        dallan_gecerli = 1'b0;
        chk("q_empty_redir3", 32'(beklenen_q.size()), 32'd0);
        bekle_dizi(32'h200, 4);
        @(negedge clk); chk("redir3_n1_valid", 32'(bif.buyruk_gecerli), 32'd0);
        chk("hata_sticky", 32'(hizasiz_hata), 32'd1); nxt();
        @(negedge clk); chk("redir3_n2_valid", 32'(bif.buyruk_gecerli), 32'd0); nxt();
        @(negedge clk); chk("redir3_n3_pc", bif.buyruk_pc, 32'h200); nxt();
        repeat (3) nxt();

        // Asynchronous reset mid-stream, away from any clock edge.
        #1;
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(bif.buyruk_gecerli), 32'd0);
        chk("async_pc", bif.buyruk_pc, 32'h0);
        chk("async_instr", bif.buyruk, 32'h0);
        chk("async_hata", 32'(hizasiz_hata), 32'd0);
        chk("async_adres", bellek_adres, 32'h0);
        chk("q_empty_reset", 32'(beklenen_q.size()), 32'd0);
        repeat (2) nxt();

        rst = 1'b1;
        bekle_dizi(32'h0, 4);
        @(negedge clk); chk("r_c0_valid", 32'(bif.buyruk_gecerli), 32'd0); nxt();
        @(negedge clk); chk("r_c1_valid", 32'(bif.buyruk_gecerli), 32'd0); nxt();
        @(negedge clk); chk("r_c2_valid", 32'(bif.buyruk_gecerli), 32'd1);
        chk("r_c2_pc", bif.buyruk_pc, 32'h0); nxt();
        repeat (3) nxt();
        bif.buyruk_hazir = 1'b0;
        @(negedge clk); chk("r_c6_pc", bif.buyruk_pc, 32'h10);
        chk("q_empty_end", 32'(beklenen_q.size()), 32'd0);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
